macu_drain: RTL
===============

# macu_drain

Result-side drain for a column of MAC cells. It accepts the signed partial-sum stream leaving the bottom of the chain and accumulates a configured number of partial sums per output. Each completed sum is requantized back to signed 8-bit with round-half-up shift and saturation, and results are buffered in a small FIFO behind a valid/ready output. The MAC chain has no backpressure, so lost results are flagged rather than stalled.

## Interface
- `DW`, 8: output data width (signed).
- `OW`, 19: input partial-sum width (signed, matches MAC cell `co`).
- `AW`, 27: accumulator width; must be ≥ `OW`+8.
- `FD`, 4: output FIFO depth (power of two, ≥2).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin a job; latches cfg, clears accumulator, counters and sticky flags.
- `cfg_tiles`  in  8  partial sums per output; 0 treated as 1.
- `cfg_groups`  in  8  outputs per job; 0 treated as 1.
- `cfg_shift`  in  5  arithmetic right shift for requant (0..26).
- `psum_valid`  in  1  `psum` valid this cycle.
- `psum`  in  OW  signed partial sum.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_data`  out  DW  FIFO head.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `ovf`  out  1  sticky: a result was dropped on full FIFO.
- `sat`  out  1  sticky: a result was saturated.

## Operation
- States: IDLE, ACC, FLUSH.
- IDLE:
  - `start` → ACC and latches cfg.
  - `psum_valid` ignored.
- ACC:
  - Each `psum_valid` adds sign-extended `psum` to `acc` (AW bits, two's-complement wrap, undetected) and increments `tcnt`.
  - On the valid that makes `tcnt` = tiles:
    - form `sum = acc + sext(psum)`;
    - register `r = requant(sum)` into stage register `rq` with `rq_v`=1;
    - clear `acc` and `tcnt`; increment `gcnt`.
  - If `gcnt` reaches groups on that edge → FLUSH.
  - `start` in ACC is ignored.
- FLUSH: waits one cycle for `rq_v` to drain into the FIFO, then → IDLE. `start` in FLUSH is ignored.
- Requant:
  - shift = 0: `t = sum`.
  - shift > 0: `t = (sum + 2^(shift-1)) >>> shift`, computed in AW+1 bits.
  - Saturate to [-128, 127]; set `sat` if clipped.
- FIFO write when `rq_v`=1:
  - If the FIFO is not full, or is full and popped in the same cycle, the write succeeds.
  - Otherwise the result is dropped, `ovf` is set, and the group still counts.
- FIFO read: on `out_valid & out_ready`. Simultaneous read and write keeps the count unchanged.
- `start` clears `ovf`, `sat`, `acc`, `tcnt`, `gcnt`. It does not flush the FIFO.
- Reset values:
  - State IDLE.
  - `acc`, `tcnt`, `gcnt`, `rq`, `rq_v` = 0.
  - FIFO empty.
  - `out_valid`=0, `out_data`=0, `busy`=0, `ovf`=0, `sat`=0.
  - Reset mid-job discards everything, including FIFO contents.

## Timing
- Final psum accepted at edge N → `rq` valid after N → FIFO written at edge N+1 → `out_valid` high after N+1. Latency is 2 cycles.
- Throughput: one psum per cycle. With tiles=1, one result per cycle sustained while `out_ready`=1.
- `out_data` is the registered FIFO head; it is stable while `out_valid` & !`out_ready`.
- `busy` falls the cycle after FLUSH exits, and only if the FIFO is empty.

## Structure
- Package `macu_pkg`:
  - state enum `drain_state_t` {IDLE, ACC, FLUSH};
  - localparams for DW/OW defaults;
  - function `requant(sum, shift)` returning {sat_flag, data}.
- Sub-module `drain_fifo`: synchronous FIFO, depth FD, width DW, with `full`/`empty`. Data output is registered; count pointers have one extra wrap bit.
- Top holds the FSM, accumulator, counters, requant stage and sticky flags.

## Test plan
- tiles=1, groups=3, shift=0, `psum` = 5, -7, 200 back-to-back, `out_ready`=1 → out_data 5, -7, 127 (sat=1), each 2 cycles after its input, then `busy`=0.
- tiles=4, groups=1, shift=2, `psum` = 10, 20, 30, 41 (sum 101) → single output 25 ((101+2)>>>2). Then sum -6 with shift 2 → -1 (round half up).
- tiles=2, groups=8, `out_ready`=0: 16 psums of value 1 → FIFO holds four 2s, `ovf`=1, FSM returns to IDLE. Raising `out_ready` drains exactly 4 values.
- FIFO full with `out_ready`=1 on the same cycle as a new result → no drop, `ovf` stays 0, count unchanged.
- `start` pulsed in ACC mid-group and `psum_valid` in IDLE → both ignored; the group completes with the original cfg.
- `rst` asserted mid-accumulation with FIFO non-empty → next cycle `out_valid`=0, `busy`=0, `ovf`=`sat`=0. A fresh job afterwards produces correct results.

Source files
------------

// File: rtl/macu_pkg.sv
// macu_pkg: shared types, default widths and the requantizer for the MAC result drain.
package macu_pkg;
  localparam int DW_DEF = 8;
  localparam int OW_DEF = 19;
  localparam int AW_DEF = 27;
  typedef enum logic [1:0] {IDLE, ACC, FLUSH} drain_state_t;
  // Returns {clipped, data}; rounding is half-up and done one bit wider than the accumulator.
  function automatic logic [DW_DEF:0] requant(input logic signed [AW_DEF-1:0] sum, input logic [4:0] shift);
    logic signed [AW_DEF:0] s, t, max_v, min_v;
    s = sum;
    max_v = (AW_DEF+1)'(2 ** (DW_DEF - 1) - 1);
    min_v = -(AW_DEF+1)'(2 ** (DW_DEF - 1));
    t = (shift == 5'd0) ? s : (s + ((AW_DEF+1)'(1) <<< (shift - 5'd1))) >>> shift;
    return (t > max_v) ? {1'b1, max_v[DW_DEF-1:0]} :
           (t < min_v) ? {1'b1, min_v[DW_DEF-1:0]} : {1'b0, t[DW_DEF-1:0]};
  endfunction
endpackage

// File: rtl/drain_fifo.sv
// drain_fifo: synchronous FIFO with a registered head and wrap-bit pointers.
module drain_fifo #(
  parameter int DW = 8,
  parameter int FD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);
  localparam int AB = $clog2(FD);
  logic [AB:0] wp_q, wp_d, rp_q, rp_d;
  logic [DW-1:0] mem_q [FD];
  logic [DW-1:0] mem_d [FD];
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic wr, rd;
  assign empty = (wp_q == rp_q);
  assign full = (wp_q[AB] != rp_q[AB]) && (wp_q[AB-1:0] == rp_q[AB-1:0]);
  assign rd = rd_en & ~empty;
  assign wr = wr_en & (~full | rd);
  assign rd_data = rd_data_q;
  // The head register looks ahead through this cycle's write and pop.
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wp_q[AB-1:0]] = wr_data;
    wp_d = wp_q + (AB+1)'(wr);
    rp_d = rp_q + (AB+1)'(rd);
    rd_data_d = mem_d[rp_d[AB-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      rd_data_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      rd_data_q <= rd_data_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/macu_drain.sv
// macu_drain: accumulates partial sums per output, requantizes to 8 bits and buffers results.
module macu_drain
  import macu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF,
  parameter int AW = AW_DEF,
  parameter int FD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    cfg_tiles,
  input  logic [7:0]    cfg_groups,
  input  logic [4:0]    cfg_shift,
  input  logic          psum_valid,
  input  logic [OW-1:0] psum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          ovf,
  output logic          sat
);
  drain_state_t state_q, state_d;
  logic [7:0] tiles_q, tiles_d, groups_q, groups_d, tcnt_q, tcnt_d, gcnt_q, gcnt_d;
  logic [7:0] tiles_eff, groups_eff;
  logic [4:0] shift_q, shift_d;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [DW-1:0] rq_q, rq_d;
  logic [DW:0] rq_res;
  logic rq_v_q, rq_v_d, ovf_q, ovf_d, sat_q, sat_d, full, empty;
  assign tiles_eff = (tiles_q == 8'd0) ? 8'd1 : tiles_q;
  assign groups_eff = (groups_q == 8'd0) ? 8'd1 : groups_q;
  assign sum = acc_q + {{(AW-OW){psum[OW-1]}}, psum};
  assign rq_res = requant(sum, shift_q);
  always_comb begin
    state_d = state_q;
    tiles_d = tiles_q;
    groups_d = groups_q;
    shift_d = shift_q;
    acc_d = acc_q;
    tcnt_d = tcnt_q;
    gcnt_d = gcnt_q;
    rq_d = rq_q;
    rq_v_d = 1'b0;
    sat_d = sat_q;
    ovf_d = ovf_q | (rq_v_q & full & ~out_ready);
    case (state_q)
      IDLE: if (start) begin
        state_d = ACC;
        tiles_d = cfg_tiles;
        groups_d = cfg_groups;
        shift_d = cfg_shift;
        acc_d = '0;
        tcnt_d = '0;
        gcnt_d = '0;
        ovf_d = 1'b0;
        sat_d = 1'b0;
      end
      ACC: if (psum_valid) begin
        if (tcnt_q + 8'd1 == tiles_eff) begin
          rq_d = rq_res[DW-1:0];
          rq_v_d = 1'b1;
          sat_d = sat_q | rq_res[DW];
          acc_d = '0;
          tcnt_d = '0;
          gcnt_d = gcnt_q + 8'd1;
          state_d = (gcnt_q + 8'd1 == groups_eff) ? FLUSH : ACC;
        end else begin
          acc_d = sum;
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tiles_q <= '0;
      groups_q <= '0;
      shift_q <= '0;
      acc_q <= '0;
      tcnt_q <= '0;
      gcnt_q <= '0;
      rq_q <= '0;
      rq_v_q <= 1'b0;
      ovf_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      groups_q <= groups_d;
      shift_q <= shift_d;
      acc_q <= acc_d;
      tcnt_q <= tcnt_d;
      gcnt_q <= gcnt_d;
      rq_q <= rq_d;
      rq_v_q <= rq_v_d;
      ovf_q <= ovf_d;
      sat_q <= sat_d;
    end
  end
  drain_fifo #(.DW(DW), .FD(FD)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(rq_v_q),
    .wr_data(rq_q),
    .rd_en(out_ready),
    .rd_data(out_data),
    .full(full),
    .empty(empty)
  );
  assign out_valid = ~empty;
  assign busy = (state_q != IDLE) | ~empty;
  assign ovf = ovf_q;
  assign sat = sat_q;
endmodule
